// File: rtl/asic_iopoc_pkg.sv
// Shared types for the IO-ring power-on-control sequencer: state encoding,
// per-state pad control decode and counter sizing.
package asic_iopoc_pkg;

  typedef enum logic [2:0] {
    StOff    = 3'd0,
    StSettle = 3'd1,
    StPocRel = 3'd2,
    StEnable = 3'd3,
    StReady  = 3'd4,
    StHold   = 3'd5
  } state_e;

  typedef struct packed {
    logic poc;
    logic pad_enable;
    logic pad_hold_n;
    logic ready;
  } pad_ctrl_t;

  localparam pad_ctrl_t OutOff    = '{poc: 1'b1, pad_enable: 1'b0, pad_hold_n: 1'b0, ready: 1'b0};
  localparam pad_ctrl_t OutPocRel = '{poc: 1'b0, pad_enable: 1'b0, pad_hold_n: 1'b0, ready: 1'b0};
  localparam pad_ctrl_t OutEnable = '{poc: 1'b0, pad_enable: 1'b1, pad_hold_n: 1'b0, ready: 1'b0};
  localparam pad_ctrl_t OutReady  = '{poc: 1'b0, pad_enable: 1'b1, pad_hold_n: 1'b1, ready: 1'b1};
  localparam pad_ctrl_t OutHold   = '{poc: 1'b0, pad_enable: 1'b1, pad_hold_n: 1'b0, ready: 1'b0};

  function automatic int unsigned cnt_width(input int unsigned settle, input int unsigned gap);
    int unsigned m;
    m = (settle > gap) ? settle : gap;
    return $clog2(m + 1);
  endfunction

  function automatic pad_ctrl_t decode(input state_e s);
    case (s)
      StPocRel: return OutPocRel;
      StEnable: return OutEnable;
      StReady:  return OutReady;
      StHold:   return OutHold;
      default:  return OutOff;
    endcase
  endfunction

endpackage

// File: rtl/asic_iopoc_sync.sv
// Multi-flop synchroniser for asynchronous monitor inputs; clears to 0 on reset.
module asic_iopoc_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/asic_iopoc_seq.sv
// Power-on-control sequencer: holds the IO ring safe until the supply has been
// stable long enough, then releases poc, enables pads and un-holds them.
module asic_iopoc_seq
  import asic_iopoc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned GAP_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vdd_ok_async,
  input  logic       sw_hold,
  output logic       poc,
  output logic       pad_enable,
  output logic       pad_hold_n,
  output logic       ready,
  output logic [2:0] state
);

  localparam int unsigned CntW = cnt_width(SETTLE_CYCLES, GAP_CYCLES);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast    = CntW'(GAP_CYCLES - 1);

  logic            vdd_ok_s;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  pad_ctrl_t       ctrl_q, ctrl_d;

  asic_iopoc_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (vdd_ok_async),
    .q  (vdd_ok_s)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StOff: begin
        cnt_d = '0;
        if (vdd_ok_s) state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          state_d = StPocRel;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StPocRel: begin
        if (cnt_q == GapLast) begin
          state_d = StEnable;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StEnable: state_d = StReady;
      StReady:  if (sw_hold) state_d = StHold;
      StHold:   if (!sw_hold) state_d = StReady;
      default: begin
        state_d = StOff;
        cnt_d   = '0;
      end
    endcase
    // Brown-out overrides every other transition, including sw_hold.
    if (!vdd_ok_s && state_q != StOff) begin
      state_d = StOff;
      cnt_d   = '0;
    end
    ctrl_d = decode(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StOff;
      cnt_q   <= '0;
      ctrl_q  <= OutOff;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign poc        = ctrl_q.poc;
  assign pad_enable = ctrl_q.pad_enable;
  assign pad_hold_n = ctrl_q.pad_hold_n;
  assign ready      = ctrl_q.ready;
  assign state      = state_q;

endmodule

// File: tb/tb_asic_iopoc_seq.sv
// Scoreboard bench for asic_iopoc_seq: the model derives each cycle's expected
// outputs from how long the synchronised supply has been continuously good.
module tb_asic_iopoc_seq;

  localparam int unsigned NSYNC = 2;
  localparam int unsigned S     = 16;
  localparam int unsigned G     = 4;
  localparam int unsigned HCap  = 10000;
  localparam logic [6:0]  RstVec = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst;
  logic       vdd_ok_async;
  logic       sw_hold;
  logic       poc, pad_enable, pad_hold_n, ready;
  logic [2:0] state;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [6:0]  exp_q[$];
  bit          hist[$];
  int unsigned h;

  asic_iopoc_seq #(
    .SYNC_STAGES  (NSYNC),
    .SETTLE_CYCLES(S),
    .GAP_CYCLES   (G)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vdd_ok_async(vdd_ok_async),
    .sw_hold     (sw_hold),
    .poc         (poc),
    .pad_enable  (pad_enable),
    .pad_hold_n  (pad_hold_n),
    .ready       (ready),
    .state       (state)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dut_vec();
    return {state, poc, pad_enable, pad_hold_n, ready};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b required=%b ({state,poc,en,hold_n,rdy})",
               name, $time, act, exp);
    end
  endtask

  function automatic void model_clear();
    h = 0;
    hist.delete();
    for (int i = 0; i < NSYNC; i++) hist.push_back(1'b0);
  endfunction

  // h counts consecutive edges at which the synchronised supply was seen good.
  function automatic logic [6:0] model_edge(input bit v, input bit hold, input bit r);
    bit          s;
    logic [2:0]  st;
    logic [3:0]  o;
    if (r) begin
      model_clear();
      return RstVec;
    end
    s = hist.pop_front();
    hist.push_back(v);
    if (s) h = (h < HCap) ? h + 1 : h;
    else   h = 0;
    if (h == 0)                       st = 3'd0;
    else if (h <= S)                  st = 3'd1;
    else if (h <= S + G)              st = 3'd2;
    else if (h == S + G + 1)          st = 3'd3;
    else if (h >= S + G + 3 && hold)  st = 3'd5;
    else                              st = 3'd4;
    case (st)
      3'd2:    o = 4'b0000;
      3'd3:    o = 4'b0100;
      3'd4:    o = 4'b0111;
      3'd5:    o = 4'b0100;
      default: o = 4'b1000;
    endcase
    return {st, o};
  endfunction

  task automatic step(input bit v, input bit hold, input bit r);
    @(negedge clk);
    vdd_ok_async = v;
    sw_hold      = hold;
    rst          = r;
    @(posedge clk);
    exp_q.push_back(model_edge(v, hold, r));
  endtask

  task automatic run(input int unsigned n, input bit v, input bit hold);
    for (int i = 0; i < n; i++) step(v, hold, 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check("cycle", dut_vec(), exp_q.pop_front());
  end

  initial begin
    bit          rv;
    bit          rh;
    int unsigned len;
    rst          = 1'b0;
    vdd_ok_async = 1'b0;
    sw_hold      = 1'b0;
    model_clear();
    #1 rst = 1'b1;
    #1 check("reset_async", dut_vec(), RstVec);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Basic bring-up, then a software hold in READY.
    run(30, 1'b1, 1'b0);
    run(5, 1'b1, 1'b1);
    run(4, 1'b1, 1'b0);

    // Brown-out from READY and full re-sequence.
    run(5, 1'b0, 1'b0);
    run(30, 1'b1, 1'b0);

    // One-cycle glitch during SETTLE restarts the settle count.
    run(4, 1'b0, 1'b0);
    run(10, 1'b1, 1'b0);
    run(1, 1'b0, 1'b0);
    run(30, 1'b1, 1'b0);

    // sw_hold held through bring-up, then brown-out while in HOLD.
    run(4, 1'b0, 1'b0);
    run(30, 1'b1, 1'b1);
    run(4, 1'b0, 1'b1);
    run(2, 1'b0, 1'b0);

    // Asynchronous reset between edges while in POC_REL.
    run(20, 1'b1, 1'b0);
    #2 rst = 1'b1;
    exp_q.delete();
    #1 check("reset_mid_pocrel", dut_vec(), RstVec);
    model_clear();
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    run(30, 1'b1, 1'b0);

    // Randomised supply runs and hold toggling.
    rh = 1'b0;
    for (int blk = 0; blk < 40; blk++) begin
      len = $urandom_range(1, 40);
      rv  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) rh = ~rh;
        step(rv, rh, 1'b0);
      end
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
